// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, memory-busy freeze and taken-branch flush
// control for a 5-stage pipeline.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined;
// otherwise stall_cycles and flush_events read as constant zero.
module hazard_unit #(
   parameter int REGW     = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNTW     = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemReadEX,
   input  logic [REGW-1:0] writeregEX,
   input  logic [REGW-1:0] insrs,
   input  logic [REGW-1:0] insrt,
   input  logic            usesrs,
   input  logic            usesrt,
   input  logic            BranchTakenEX,
   input  logic            MemBusy,
   output logic            PChold,
   output logic            IFIDhold,
   output logic            IDEXhold,
   output logic            EXMEMhold,
   output logic            IDEXbubble,
   output logic            IFIDflush,
   output logic [CNTW-1:0] stall_cycles,
   output logic [CNTW-1:0] flush_events
);

   typedef enum logic {
      IDLE   = 1'b0,
      LDWAIT = 1'b1
   } state_t;

   // Remaining stall cycles after the first one taken in IDLE.
   localparam logic [3:0] CNT_INIT = 4'(LOAD_LAT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic       hazard;

   // Only rs/rt are compared; register 0 never creates a dependency.
   assign hazard = MemReadEX && (writeregEX != '0) &&
                   ((usesrs && (writeregEX == insrs)) ||
                    (usesrt && (writeregEX == insrt)));

   // State and stall counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and control outputs, priority MemBusy > load stall > branch flush.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      PChold     = 1'b0;
      IFIDhold   = 1'b0;
      IDEXhold   = 1'b0;
      EXMEMhold  = 1'b0;
      IDEXbubble = 1'b0;
      IFIDflush  = 1'b0;
      if (!reset) begin
         if (MemBusy) begin
            PChold    = 1'b1;
            IFIDhold  = 1'b1;
            IDEXhold  = 1'b1;
            EXMEMhold = 1'b1;
         end else if (state == LDWAIT) begin
            PChold     = 1'b1;
            IFIDhold   = 1'b1;
            IDEXbubble = 1'b1;
            cnt_nxt    = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = IDLE;
            end
         end else if (hazard) begin
            PChold     = 1'b1;
            IFIDhold   = 1'b1;
            IDEXbubble = 1'b1;
            if (LOAD_LAT > 1) begin
               cnt_nxt   = CNT_INIT;
               state_nxt = LDWAIT;
            end
         end else if (BranchTakenEX) begin
            IFIDflush  = 1'b1;
            IDEXbubble = 1'b1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   // Wrapping event counters for stall cycles and flushes.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (PChold) begin
            stall_cycles <= stall_cycles + CNTW'(1);
         end
         if (IFIDflush) begin
            flush_events <= flush_events + CNTW'(1);
         end
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (LOAD_LAT=1 and LOAD_LAT=3) share the
// same stimulus; a remaining-stall-count model predicts every output each cycle.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       MemReadEX;
   logic [4:0] writeregEX;
   logic [4:0] insrs;
   logic [4:0] insrt;
   logic       usesrs;
   logic       usesrt;
   logic       BranchTakenEX;
   logic       MemBusy;

   logic        pch1, ifh1, idh1, exh1, bub1, fl1;
   logic        pch3, ifh3, idh3, exh3, bub3, fl3;
   logic [31:0] sc1, fe1, sc3, fe3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_unit #(.REGW(5), .LOAD_LAT(1), .CNTW(32)) u_lat1 (
      .clk(clk), .reset(reset), .MemReadEX(MemReadEX), .writeregEX(writeregEX),
      .insrs(insrs), .insrt(insrt), .usesrs(usesrs), .usesrt(usesrt),
      .BranchTakenEX(BranchTakenEX), .MemBusy(MemBusy),
      .PChold(pch1), .IFIDhold(ifh1), .IDEXhold(idh1), .EXMEMhold(exh1),
      .IDEXbubble(bub1), .IFIDflush(fl1),
      .stall_cycles(sc1), .flush_events(fe1)
   );

   hazard_unit #(.REGW(5), .LOAD_LAT(3), .CNTW(32)) u_lat3 (
      .clk(clk), .reset(reset), .MemReadEX(MemReadEX), .writeregEX(writeregEX),
      .insrs(insrs), .insrt(insrt), .usesrs(usesrs), .usesrt(usesrt),
      .BranchTakenEX(BranchTakenEX), .MemBusy(MemBusy),
      .PChold(pch3), .IFIDhold(ifh3), .IDEXhold(idh3), .EXMEMhold(exh3),
      .IDEXbubble(bub3), .IFIDflush(fl3),
      .stall_cycles(sc3), .flush_events(fe3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a load-use stall is "lat cycles of PChold", counted down as rem.
   function automatic logic [5:0] model_out(input int lat, input int rem, output int rem_n);
      logic hz;
      hz = MemReadEX && (writeregEX != 0) &&
           ((usesrs && writeregEX == insrs) || (usesrt && writeregEX == insrt));
      rem_n = rem;
      // order: PChold IFIDhold IDEXhold EXMEMhold IDEXbubble IFIDflush
      if (reset) begin
         rem_n = 0;
         return 6'b000000;
      end
      if (MemBusy) return 6'b111100;
      if (rem > 0) begin
         rem_n = rem - 1;
         return 6'b110010;
      end
      if (hz) begin
         rem_n = lat - 1;
         return 6'b110010;
      end
      if (BranchTakenEX) return 6'b000011;
      return 6'b000000;
   endfunction

   // Per-cycle comparison against the model, sampled mid-cycle on the falling edge.
   initial begin
      int          rem1 = 0, rem3 = 0, nr;
      logic [31:0] msc1 = 0, mfe1 = 0, msc3 = 0, mfe3 = 0;
      logic [5:0]  e1, e3;
      @(posedge clk);
      forever begin
         @(negedge clk);
         e1 = model_out(1, rem1, nr); rem1 = nr;
         e3 = model_out(3, rem3, nr); rem3 = nr;
         check("outs_lat1", {pch1, ifh1, idh1, exh1, bub1, fl1}, e1);
         check("outs_lat3", {pch3, ifh3, idh3, exh3, bub3, fl3}, e3);
`ifdef HAZARD_STATS_EN
         check("stall_cnt_lat1", sc1, msc1);
         check("flush_cnt_lat1", fe1, mfe1);
         check("stall_cnt_lat3", sc3, msc3);
         check("flush_cnt_lat3", fe3, mfe3);
         msc1 = reset ? 0 : msc1 + e1[5];
         mfe1 = reset ? 0 : mfe1 + e1[0];
         msc3 = reset ? 0 : msc3 + e3[5];
         mfe3 = reset ? 0 : mfe3 + e3[0];
`else
         check("stall_cnt_lat1", sc1, 32'd0);
         check("flush_cnt_lat1", fe1, 32'd0);
         check("stall_cnt_lat3", sc3, 32'd0);
         check("flush_cnt_lat3", fe3, 32'd0);
`endif
      end
   end

   int pc1, pc3, ex1, ex3, bb1, bb3, ff1, ff3;

   task automatic clr_acc();
      pc1 = 0; pc3 = 0; ex1 = 0; ex3 = 0; bb1 = 0; bb3 = 0; ff1 = 0; ff3 = 0;
   endtask

   // Sample the combinational outputs for the current inputs, then advance one cycle.
   task automatic tick();
      #2;
      pc1 += pch1; pc3 += pch3; ex1 += exh1; ex3 += exh3;
      bb1 += bub1; bb3 += bub3; ff1 += fl1;  ff3 += fl3;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MemReadEX = 0; writeregEX = 0; insrs = 0; insrt = 0;
      usesrs = 0; usesrt = 0; BranchTakenEX = 0; MemBusy = 0;
   endtask

   task automatic rt_hazard();
      MemReadEX = 1; writeregEX = 5; insrt = 5; usesrt = 1; insrs = 0; usesrs = 0;
   endtask

   initial begin
      logic [31:0] sc3_before;
      reset = 1;
      idle_inputs();
      repeat (3) tick();
      reset = 0;
      tick();

      // Single-cycle load-use hazard on rt.
      clr_acc();
      sc3_before = sc3;
      rt_hazard();
      tick();
      MemReadEX = 0;
      repeat (4) tick();
      check("lu_pchold_lat1", pc1, 1);
      check("lu_pchold_lat3", pc3, 3);
      check("lu_bubble_lat1", bb1, 1);
      check("lu_bubble_lat3", bb3, 3);
`ifdef HAZARD_STATS_EN
      check("lu_stat_lat3", sc3 - sc3_before, 3);
`else
      check("lu_stat_lat3", sc3 - sc3_before, 0);
`endif

      // Register 0 and an unused rt never stall.
      clr_acc();
      idle_inputs();
      MemReadEX = 1; writeregEX = 0; insrs = 0; usesrs = 1;
      tick();
      usesrs = 0; insrs = 3; writeregEX = 7; insrt = 7; usesrt = 0;
      tick();
      MemReadEX = 0;
      tick();
      check("nohz_pchold_lat1", pc1, 0);
      check("nohz_pchold_lat3", pc3, 0);

      // MemBusy for two cycles starting in the second stall cycle.
      clr_acc();
      idle_inputs();
      rt_hazard();
      tick();
      MemReadEX = 0; MemBusy = 1;
      repeat (2) tick();
      MemBusy = 0;
      repeat (4) tick();
      check("busy_pchold_lat3", pc3, 5);
      check("busy_pchold_lat1", pc1, 3);
      check("busy_exmem_lat3", ex3, 2);
      check("busy_bubble_lat3", bb3, 3);
      check("busy_bubble_lat1", bb1, 1);

      // Taken branch flushes once; the same branch under MemBusy does not.
      clr_acc();
      idle_inputs();
      BranchTakenEX = 1;
      tick();
      BranchTakenEX = 0;
      tick();
      BranchTakenEX = 1; MemBusy = 1;
      tick();
      BranchTakenEX = 0; MemBusy = 0;
      tick();
      check("br_flush_lat1", ff1, 1);
      check("br_flush_lat3", ff3, 1);
      check("br_bubble_lat3", bb3, 1);
      check("br_exmem_lat1", ex1, 1);

      // Reset in the second LDWAIT cycle.
      clr_acc();
      idle_inputs();
      rt_hazard();
      tick();
      MemReadEX = 0;
      tick();
      reset = 1;
      tick();
      reset = 0;
      repeat (2) tick();
      check("rst_pchold_lat3", pc3, 2);
      check("rst_stat_lat3", sc3, 0);
      check("rst_flush_lat3", fe3, 0);

      // Randomized traffic over a small register space.
      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 99) < 2);
         MemReadEX     = ($urandom_range(0, 99) < 50);
         writeregEX    = 5'($urandom_range(0, 3));
         insrs         = 5'($urandom_range(0, 3));
         insrt         = 5'($urandom_range(0, 3));
         usesrs        = ($urandom_range(0, 99) < 60);
         usesrt        = ($urandom_range(0, 99) < 60);
         BranchTakenEX = ($urandom_range(0, 99) < 30);
         MemBusy       = ($urandom_range(0, 99) < 20);
         tick();
      end

      idle_inputs();
      reset = 0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REGW, default 5: register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1: load-use stall cycles, legal range 1..15.
REQ-003 SHALL have parameter CNTW, default 32: statistics counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, named as below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 MemReadEX  in  1  instruction in EX is a load.
REQ-008 writeregEX  in  REGW  destination register of the EX instruction.
REQ-009 insrs, insrt  in  REGW each  source registers of the ID instruction.
REQ-010 usesrs, usesrt  in  1 each  ID instruction actually reads rs / rt.
REQ-011 BranchTakenEX  in  1  branch or jump resolved taken in EX.
REQ-012 MemBusy  in  1  data memory not ready; pipeline must freeze.
REQ-013 PChold, IFIDhold, IDEXhold, EXMEMhold  out  1 each  stage-register hold enables.
REQ-014 IDEXbubble, IFIDflush  out  1 each  insert NOP into ID/EX; clear IF/ID.
REQ-015 stall_cycles, flush_events  out  CNTW each  statistics counters (see Configuration).

Function
REQ-016 SHALL detect a hazard as MemReadEX and writeregEX!=0 and ((usesrs and writeregEX==insrs) or (usesrt and writeregEX==insrt)); rd SHALL NOT be compared.
REQ-017 SHALL implement FSM states IDLE and LDWAIT plus a 4-bit down-counter cnt.
REQ-018 In IDLE with a hazard and MemBusy=0, SHALL assert PChold, IFIDhold and IDEXbubble combinationally in the same cycle.
REQ-019 If LOAD_LAT>1, SHALL load cnt=LOAD_LAT-1 and enter LDWAIT on that edge; otherwise SHALL stay in IDLE.
REQ-020 In LDWAIT, SHALL assert PChold, IFIDhold and IDEXbubble each cycle and decrement cnt; SHALL return to IDLE on the edge where cnt==1.
REQ-021 A load-use stall SHALL last exactly LOAD_LAT cycles when MemBusy=0 throughout.
REQ-022 MemBusy=1 SHALL assert PChold, IFIDhold, IDEXhold and EXMEMhold, and force IDEXbubble=0 and IFIDflush=0.
REQ-023 While MemBusy=1, the state and cnt SHALL be frozen; hazard detection in IDLE SHALL take effect on the first cycle MemBusy=0.
REQ-024 BranchTakenEX=1 in IDLE with no hazard and MemBusy=0 SHALL assert IFIDflush and IDEXbubble for that cycle.
REQ-025 Priority SHALL be MemBusy > load stall (IDLE hazard or LDWAIT) > branch flush.
REQ-026 A branch masked by a higher-priority condition SHALL NOT be remembered; the upstream holds keep it in EX.
REQ-027 IDEXhold and EXMEMhold SHALL be asserted only under MemBusy.
REQ-028 All outputs SHALL be 0 when no condition applies.

Reset
REQ-029 reset=1 at a rising edge SHALL set state=IDLE, cnt=0 and both counters to 0.
REQ-030 While reset=1, all hold, bubble and flush outputs SHALL be forced to 0.
REQ-031 Reset SHALL have priority over everything, including mid-LDWAIT and during MemBusy.

Configuration
REQ-032 Macro HAZARD_STATS_EN defined: stall_cycles SHALL increment (wrapping) on every cycle with PChold=1.
REQ-033 Macro HAZARD_STATS_EN defined: flush_events SHALL increment (wrapping) on every cycle with IFIDflush=1.
REQ-034 Macro HAZARD_STATS_EN undefined: stall_cycles and flush_events SHALL be constant 0, no counter registers SHALL be built, and the ports SHALL remain present.

Verification
REQ-035 LOAD_LAT=1, MemReadEX=1, writeregEX=5, insrt=5, usesrt=1 -> PChold, IFIDhold and IDEXbubble are 1 for exactly 1 cycle.
REQ-036 LOAD_LAT=3, same hazard for one cycle, then MemReadEX=0 -> stall lasts 3 cycles, then IDLE; stall_cycles=3 with HAZARD_STATS_EN.
REQ-037 writeregEX=0 with insrs=0, or writeregEX=7 with insrt=7 and usesrt=0 -> no stall.
REQ-038 LOAD_LAT=3, MemBusy=1 for 2 cycles during the 2nd stall cycle -> all four holds high, IDEXbubble=0, stall resumes, total PChold-high cycles=5.
REQ-039 BranchTakenEX=1 with no hazard -> IFIDflush=1 and IDEXbubble=1 for 1 cycle; same cycle with MemBusy=1 -> no flush.
REQ-040 reset asserted in the 2nd LDWAIT cycle -> outputs 0 in that cycle, state=IDLE, counters=0 after the edge.
